// File: rtl/host_frame_writer.sv
// host_frame_writer
//   Turns host commands (connect / disconnect / send) into framed words written
//   into a downstream FIFO.  Frame layout:
//     CONNECT, DISCONNECT : HDR
//     SEND                : HDR, LEN, payload words..., CSUM (when CSUM_EN)
//   HDR  = zero-extended {addr, opcode}
//   LEN  = (length + LEN_OFFSET) mod 2^DW
//   CSUM = XOR of all payload words of the frame
//   HOST_AW + 3 must not exceed DW so the header fits in one word.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   full_i                   downstream FIFO full; stalls any write
//   connect_req_i            connect request (level, held until cmd_ack_o)
//   connect_host_addr_i      address used by connect and send
//   disconnect_req_i         disconnect request (level)
//   disconnect_addr_i        address used by disconnect
//   send_req_i               send request (level)
//   message_length_i         send payload length in words
//   payload_valid_i/data_i   payload word offered by the source
//   payload_ready_o          payload word taken this cycle (combinational)
//   cmd_ack_o                registered pulse: a command was taken
//   busy_o                   registered: FSM is not idle
//   len_err_o                registered pulse: send rejected for its length
//   writereq_o, data_o       FIFO write strobe and data (combinational)
module host_frame_writer #(
    parameter int          HOST_AW    = 4,
    parameter int          DW         = 8,
    parameter int          LEN_OFFSET = 21,
    parameter int unsigned MAX_LEN    = 255,
    parameter int          CSUM_EN    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               full_i,
    input  logic               connect_req_i,
    input  logic [HOST_AW-1:0] connect_host_addr_i,
    input  logic               disconnect_req_i,
    input  logic [HOST_AW-1:0] disconnect_addr_i,
    input  logic               send_req_i,
    input  logic [7:0]         message_length_i,
    input  logic               payload_valid_i,
    input  logic [DW-1:0]      payload_data_i,
    output logic               payload_ready_o,
    output logic               cmd_ack_o,
    output logic               busy_o,
    output logic               len_err_o,
    output logic               writereq_o,
    output logic [DW-1:0]      data_o
);

    localparam logic [2:0] OP_CONNECT    = 3'b000;
    localparam logic [2:0] OP_DISCONNECT = 3'b001;
    localparam logic [2:0] OP_SEND       = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_PAY,
        S_CSUM
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_op;
    logic [HOST_AW-1:0] r_addr;
    logic [7:0]         r_len;
    logic [7:0]         r_cnt;
    logic [DW-1:0]      r_csum;
    logic               r_cmd_ack;
    logic               r_len_err;
    logic               r_busy;

    logic               w_accept;
    logic               w_reject;
    logic               w_xfer;
    logic [2:0]         w_sel_op;
    logic [HOST_AW-1:0] w_sel_addr;
    logic [7:0]         w_sel_len;
    logic [DW-1:0]      w_hdr;
    logic [DW-1:0]      w_len_word;
    state_t             w_after_pay;

    assign w_hdr       = DW'({r_addr, r_op});
    assign w_len_word  = DW'(r_len) + DW'(LEN_OFFSET);
    assign w_after_pay = (CSUM_EN != 0) ? S_CSUM : S_IDLE;

    assign cmd_ack_o = r_cmd_ack;
    assign len_err_o = r_len_err;
    assign busy_o    = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_reject        = 1'b0;
        w_xfer          = 1'b0;
        w_sel_op        = OP_CONNECT;
        w_sel_addr      = '0;
        w_sel_len       = '0;
        writereq_o      = 1'b0;
        data_o          = '0;
        payload_ready_o = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A rejected send leaves us in IDLE with its request still
                // asserted during the ack cycle; skip arbitration while the ack
                // is showing so the same request is not taken twice.
                if (!r_cmd_ack) begin
                    if (connect_req_i) begin
                        w_accept   = 1'b1;
                        w_sel_op   = OP_CONNECT;
                        w_sel_addr = connect_host_addr_i;
                    end else if (disconnect_req_i) begin
                        w_accept   = 1'b1;
                        w_sel_op   = OP_DISCONNECT;
                        w_sel_addr = disconnect_addr_i;
                    end else if (send_req_i) begin
                        if (32'(message_length_i) > MAX_LEN) begin
                            w_reject = 1'b1;
                        end else begin
                            w_accept   = 1'b1;
                            w_sel_op   = OP_SEND;
                            w_sel_addr = connect_host_addr_i;
                            w_sel_len  = message_length_i;
                        end
                    end
                end
                if (w_accept) begin
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (!full_i) begin
                    writereq_o  = 1'b1;
                    data_o      = w_hdr;
                    w_state_nxt = (r_op == OP_SEND) ? S_LEN : S_IDLE;
                end
            end
            S_LEN: begin
                if (!full_i) begin
                    writereq_o = 1'b1;
                    data_o     = w_len_word;
                    if (r_len != 8'd0) begin
                        w_state_nxt = S_PAY;
                    end else begin
                        w_state_nxt = w_after_pay;
                    end
                end
            end
            S_PAY: begin
                // Zero-latency pass-through: the accepted payload word is the
                // FIFO write of the same cycle.
                payload_ready_o = !full_i;
                if (payload_valid_i && !full_i) begin
                    w_xfer     = 1'b1;
                    writereq_o = 1'b1;
                    data_o     = payload_data_i;
                    if (r_cnt == 8'd1) begin
                        w_state_nxt = w_after_pay;
                    end
                end
            end
            S_CSUM: begin
                if (!full_i) begin
                    writereq_o  = 1'b1;
                    data_o      = r_csum;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= OP_CONNECT;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_csum    <= '0;
            r_cmd_ack <= 1'b0;
            r_len_err <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_cmd_ack <= w_accept | w_reject;
            r_len_err <= w_reject;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (w_accept || w_reject) begin
                r_csum <= '0;
            end else if (w_xfer) begin
                r_csum <= r_csum ^ payload_data_i;
            end
            if (w_accept) begin
                r_op   <= w_sel_op;
                r_addr <= w_sel_addr;
                r_len  <= w_sel_len;
                r_cnt  <= w_sel_len;
            end else if (w_xfer) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_host_frame_writer.sv
module tb_host_frame_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       full_i = 1'b0;
    logic       connect_req_i = 1'b0;
    logic [3:0] connect_host_addr_i = '0;
    logic       disconnect_req_i = 1'b0;
    logic [3:0] disconnect_addr_i = '0;
    logic       send_req_i = 1'b0;
    logic [7:0] message_length_i = '0;
    logic       payload_valid_i = 1'b0;
    logic [7:0] payload_data_i = '0;
    logic       payload_ready_o;
    logic       cmd_ack_o;
    logic       busy_o;
    logic       len_err_o;
    logic       writereq_o;
    logic [7:0] data_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int         wr_cyc[$];

    host_frame_writer #(
        .HOST_AW(4), .DW(8), .LEN_OFFSET(21), .MAX_LEN(16), .CSUM_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .full_i(full_i),
        .connect_req_i(connect_req_i), .connect_host_addr_i(connect_host_addr_i),
        .disconnect_req_i(disconnect_req_i), .disconnect_addr_i(disconnect_addr_i),
        .send_req_i(send_req_i), .message_length_i(message_length_i),
        .payload_valid_i(payload_valid_i), .payload_data_i(payload_data_i),
        .payload_ready_o(payload_ready_o), .cmd_ack_o(cmd_ack_o),
        .busy_o(busy_o), .len_err_o(len_err_o),
        .writereq_o(writereq_o), .data_o(data_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && writereq_o) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {24'd0, data_o}, 32'hFFFF_FFFF);
            end else begin
                chk("fifo_word", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // which: 0 connect, 1 disconnect, 2 send. Drops the request once acked.
    task automatic wait_ack(input int which, input string nm);
        int n;
        n = 0;
        while (n < 40) begin
            step();
            if (cmd_ack_o) break;
            n++;
        end
        if (n >= 40) chk({nm, "_ack_timeout"}, 32'd0, 32'd1);
        case (which)
            0: connect_req_i = 1'b0;
            1: disconnect_req_i = 1'b0;
            default: send_req_i = 1'b0;
        endcase
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy_o && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) chk({nm, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drive_payload(input logic [7:0] w0, input logic [7:0] w1);
        logic [7:0] words[2];
        logic       xfer;
        int         n;
        words[0] = w0;
        words[1] = w1;
        for (int i = 0; i < 2; i++) begin
            payload_valid_i = 1'b1;
            payload_data_i  = words[i];
            n = 0;
            xfer = 1'b0;
            while (!xfer && n < 60) begin
                @(negedge clk);
                xfer = payload_ready_o;
                step();
                n++;
            end
            if (!xfer) chk("payload_timeout", 32'd0, 32'd1);
        end
        payload_valid_i = 1'b0;
        payload_data_i  = '0;
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_writereq", {31'd0, writereq_o}, 32'd0);
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_ready", {31'd0, payload_ready_o}, 32'd0);
        chk("rst_ack", {31'd0, cmd_ack_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_lenerr", {31'd0, len_err_o}, 32'd0);
        rst_n = 1'b1;
        step();

        // Connect to 5: header 0x28
        exp_q.push_back(8'h28);
        connect_host_addr_i = 4'h5;
        connect_req_i = 1'b1;
        wait_ack(0, "connect");
        chk("connect_busy_hdr", {31'd0, busy_o}, 32'd1);
        chk("connect_no_lenerr", {31'd0, len_err_o}, 32'd0);
        step();
        chk("connect_busy_done", {31'd0, busy_o}, 32'd0);
        step();

        // Send to 3, two words, no backpressure
        wr_cyc.delete();
        exp_q.push_back(8'h1A); exp_q.push_back(8'h17);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h0F); exp_q.push_back(8'hAA);
        connect_host_addr_i = 4'h3;
        message_length_i = 8'd2;
        send_req_i = 1'b1;
        fork
            wait_ack(2, "send");
            drive_payload(8'hA5, 8'h0F);
        join
        wait_idle("send");
        step();
        chk("send_write_count", wr_cyc.size(), 32'd5);
        if (wr_cyc.size() == 5) chk("send_consecutive", wr_cyc[4] - wr_cyc[0], 32'd4);

        // Same send with 3 cycles of full_i during payload
        wr_cyc.delete();
        exp_q.push_back(8'h1A); exp_q.push_back(8'h17);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h0F); exp_q.push_back(8'hAA);
        send_req_i = 1'b1;
        fork
            begin
                wait_ack(2, "bp_send");
                repeat (3) step();
                full_i = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_ready_low", {31'd0, payload_ready_o}, 32'd0);
                    chk("bp_no_write", {31'd0, writereq_o}, 32'd0);
                    step();
                end
                full_i = 1'b0;
            end
            drive_payload(8'hA5, 8'h0F);
        join
        wait_idle("bp");
        step();
        chk("bp_write_count", wr_cyc.size(), 32'd5);
        if (wr_cyc.size() == 5) chk("bp_span", wr_cyc[4] - wr_cyc[0], 32'd7);

        // All three requests together; send has length 0
        exp_q.push_back(8'h28);
        exp_q.push_back(8'h49);
        exp_q.push_back(8'h2A); exp_q.push_back(8'h15); exp_q.push_back(8'h00);
        connect_host_addr_i = 4'h5;
        disconnect_addr_i = 4'h9;
        message_length_i = 8'd0;
        connect_req_i = 1'b1;
        disconnect_req_i = 1'b1;
        send_req_i = 1'b1;
        wait_ack(0, "arb_connect");
        wait_ack(1, "arb_disconnect");
        wait_ack(2, "arb_send");
        wait_idle("arb");
        step();
        chk("arb_queue_drained", exp_q.size(), 32'd0);

        // Length error: 20 > MAX_LEN(16)
        message_length_i = 8'd20;
        send_req_i = 1'b1;
        wait_ack(2, "lenerr");
        chk("lenerr_pulse", {31'd0, len_err_o}, 32'd1);
        chk("lenerr_not_busy", {31'd0, busy_o}, 32'd0);
        repeat (3) step();
        chk("lenerr_cleared", {31'd0, len_err_o}, 32'd0);
        chk("lenerr_ack_cleared", {31'd0, cmd_ack_o}, 32'd0);

        // Reset after the first of two payload words
        exp_q.push_back(8'h1A); exp_q.push_back(8'h17); exp_q.push_back(8'hA5);
        connect_host_addr_i = 4'h3;
        message_length_i = 8'd2;
        payload_valid_i = 1'b1;
        payload_data_i = 8'hA5;
        send_req_i = 1'b1;
        wait_ack(2, "rstpay");
        repeat (3) step();
        payload_data_i = 8'h0F;
        #1;
        chk("rstpay_pre_write", {31'd0, writereq_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstpay_writereq", {31'd0, writereq_o}, 32'd0);
        chk("rstpay_data", {24'd0, data_o}, 32'd0);
        chk("rstpay_ready", {31'd0, payload_ready_o}, 32'd0);
        chk("rstpay_busy", {31'd0, busy_o}, 32'd0);
        chk("rstpay_ack", {31'd0, cmd_ack_o}, 32'd0);
        chk("rstpay_lenerr", {31'd0, len_err_o}, 32'd0);
        payload_valid_i = 1'b0;
        payload_data_i = '0;
        step();
        rst_n = 1'b1;
        exp_q.push_back(8'h28);
        connect_host_addr_i = 4'h5;
        connect_req_i = 1'b1;
        wait_ack(0, "post_rst_connect");
        wait_idle("post_rst");
        repeat (3) step();
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
